// File: rtl/dmem_port_arbiter.sv
// ============================================================================
//  Module   : dmem_port_arbiter
//  Purpose  : Shares the data-memory port between the CPU (priority) and a
//             background req/gnt requester, with a starvation-forced grant.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module dmem_port_arbiter #(
    parameter int ADDR_W       = 14,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              iCpuClock,
    input  logic              iCpuReset,
    input  logic              iCpuMemRead,
    input  logic              iCpuMemWrite,
    input  logic [ADDR_W-1:0] iCpuAddr,
    input  logic [DATA_W-1:0] iCpuWData,
    output logic [DATA_W-1:0] oCpuRData,
    output logic              oCpuStall,
    input  logic              iDmaReq,
    input  logic              iDmaWe,
    input  logic [ADDR_W-1:0] iDmaAddr,
    input  logic [DATA_W-1:0] iDmaWData,
    output logic              oDmaGnt,
    output logic              oDmaRValid,
    output logic [DATA_W-1:0] oDmaRData,
    output logic              oRamWen,
    output logic [ADDR_W-1:0] oRamAddr,
    output logic [DATA_W-1:0] oRamWData,
    input  logic [DATA_W-1:0] iRamRData
);

    localparam logic [0:0] c_ST_CPU         = 1'b0;
    localparam logic [0:0] c_ST_FORCE       = 1'b1;
    localparam logic [3:0] c_STARVE_LIMIT   = 4'(STARVE_LIMIT);

    logic [0:0]        r_state;
    logic [3:0]        r_starve_cnt;
    logic              r_rvalid;
    logic [DATA_W-1:0] r_dma_rdata;

    logic w_cpu_access;
    logic w_cpu_own;
    logic w_dma_own;
    logic w_stall;
    logic w_denied;

    assign w_cpu_access = iCpuMemRead | iCpuMemWrite;
    assign w_denied     = (r_state == c_ST_CPU) & w_cpu_access & iDmaReq;

    // Port ownership; the port is held idle while reset is asserted.
    always_comb begin
        w_cpu_own = 1'b0;
        w_dma_own = 1'b0;
        w_stall   = 1'b0;
        if (!iCpuReset) begin
            if (r_state == c_ST_FORCE) begin
                w_stall   = 1'b1;
                w_dma_own = iDmaReq;
            end else if (w_cpu_access) begin
                w_cpu_own = 1'b1;
            end else if (iDmaReq) begin
                w_dma_own = 1'b1;
            end
        end
    end

    always_comb begin
        oRamWen   = 1'b0;
        oRamAddr  = '0;
        oRamWData = '0;
        if (w_dma_own) begin
            oRamWen   = iDmaWe;
            oRamAddr  = iDmaAddr;
            oRamWData = iDmaWData;
        end else if (!iCpuReset) begin
            oRamWen   = w_cpu_own & iCpuMemWrite;
            oRamAddr  = iCpuAddr;
            oRamWData = iCpuWData;
        end
    end

    assign oDmaGnt    = w_dma_own;
    assign oCpuStall  = w_stall;
    assign oCpuRData  = iCpuReset ? '0 : iRamRData;
    assign oDmaRValid = r_rvalid;
    assign oDmaRData  = r_rvalid ? iRamRData : r_dma_rdata;

    always_ff @(posedge iCpuClock) begin
        if (iCpuReset) begin
            r_state      <= c_ST_CPU;
            r_starve_cnt <= 4'd0;
            r_rvalid     <= 1'b0;
            r_dma_rdata  <= '0;
        end else begin
            r_rvalid <= w_dma_own & ~iDmaWe;
            if (r_rvalid) begin
                r_dma_rdata <= iRamRData;
            end
            if (r_state == c_ST_FORCE) begin
                r_state      <= c_ST_CPU;
                r_starve_cnt <= 4'd0;
            end else if (w_denied) begin
                // The LIMIT-th consecutive denial schedules the forced cycle.
                if (r_starve_cnt + 4'd1 == c_STARVE_LIMIT) begin
                    r_state      <= c_ST_FORCE;
                    r_starve_cnt <= 4'd0;
                end else begin
                    r_starve_cnt <= r_starve_cnt + 4'd1;
                end
            end else begin
                r_starve_cnt <= 4'd0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
// ============================================================================
//  Module   : tb_dmem_port_arbiter
//  Purpose  : Directed and random checks of dmem_port_arbiter against a
//             cycle-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dmem_port_arbiter;

    localparam int c_ADDR_W = 14;
    localparam int c_DATA_W = 32;
    localparam int c_LIMIT  = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic                cpu_rd, cpu_wr;
    logic [c_ADDR_W-1:0] cpu_addr;
    logic [c_DATA_W-1:0] cpu_wdata;
    logic [c_DATA_W-1:0] cpu_rdata;
    logic                cpu_stall;
    logic                dma_req, dma_we;
    logic [c_ADDR_W-1:0] dma_addr;
    logic [c_DATA_W-1:0] dma_wdata;
    logic                dma_gnt, dma_rvalid;
    logic [c_DATA_W-1:0] dma_rdata;
    logic                ram_wen;
    logic [c_ADDR_W-1:0] ram_addr;
    logic [c_DATA_W-1:0] ram_wdata;
    logic [c_DATA_W-1:0] ram_rdata;

    int total = 0;
    int bad   = 0;

    // Reference model: length of the current denial run and pending read return
    int                  m_run      = 0;
    bit                  m_rvalid   = 1'b0;
    logic [c_DATA_W-1:0] m_hold     = '0;
    bit                  m_last_gnt = 1'b0;
    bit                  m_last_stall = 1'b0;

    always #5 clk = ~clk;

    dmem_port_arbiter #(
        .ADDR_W(c_ADDR_W), .DATA_W(c_DATA_W), .STARVE_LIMIT(c_LIMIT)
    ) dut (
        .iCpuClock(clk),       .iCpuReset(rst),
        .iCpuMemRead(cpu_rd),  .iCpuMemWrite(cpu_wr),
        .iCpuAddr(cpu_addr),   .iCpuWData(cpu_wdata),
        .oCpuRData(cpu_rdata), .oCpuStall(cpu_stall),
        .iDmaReq(dma_req),     .iDmaWe(dma_we),
        .iDmaAddr(dma_addr),   .iDmaWData(dma_wdata),
        .oDmaGnt(dma_gnt),     .oDmaRValid(dma_rvalid),
        .oDmaRData(dma_rdata), .oRamWen(ram_wen),
        .oRamAddr(ram_addr),   .oRamWData(ram_wdata),
        .iRamRData(ram_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check outputs mid-cycle, then advance the model at the edge.
    task automatic step();
        bit                  forced, cpu_acc, own_cpu, own_dma;
        logic                e_wen;
        logic [c_ADDR_W-1:0] e_addr;
        logic [c_DATA_W-1:0] e_wdata, e_drdata;
        @(negedge clk);
        cpu_acc = cpu_rd | cpu_wr;
        forced  = !rst && (m_run == c_LIMIT);
        own_cpu = !rst && !forced && cpu_acc;
        own_dma = !rst && dma_req && (forced || !cpu_acc);
        e_wen    = own_dma ? dma_we : (own_cpu & cpu_wr);
        e_addr   = rst ? '0 : (own_dma ? dma_addr : cpu_addr);
        e_wdata  = rst ? '0 : (own_dma ? dma_wdata : cpu_wdata);
        e_drdata = m_rvalid ? ram_rdata : m_hold;
        chk("stall",     32'(cpu_stall),  32'(!rst && forced));
        chk("gnt",       32'(dma_gnt),    32'(own_dma));
        chk("ram_wen",   32'(ram_wen),    32'(e_wen));
        chk("ram_addr",  32'(ram_addr),   32'(e_addr));
        chk("ram_wdata", ram_wdata,       e_wdata);
        chk("rvalid",    32'(dma_rvalid), 32'(m_rvalid));
        chk("dma_rdata", dma_rdata,       e_drdata);
        chk("cpu_rdata", cpu_rdata,       rst ? 32'h0 : ram_rdata);
        m_last_gnt   = own_dma;
        m_last_stall = cpu_stall;
        @(posedge clk);
        if (rst) begin
            m_run    = 0;
            m_rvalid = 1'b0;
            m_hold   = '0;
        end else begin
            if (m_rvalid) m_hold = ram_rdata;
            m_rvalid = own_dma && !dma_we;
            if (!forced && dma_req && cpu_acc) m_run++;
            else m_run = 0;
        end
        #1;
    endtask

    task automatic idle_inputs();
        cpu_rd = 0; cpu_wr = 0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
    endtask

    initial begin
        int stalls;
        idle_inputs();
        ram_rdata = 32'h0;
        rst = 1;
        // Reset with busy inputs: port must stay idle and zeroed
        cpu_wr = 1; cpu_addr = 14'h3ff; cpu_wdata = 32'hffff_0000;
        dma_req = 1; dma_we = 1; ram_rdata = 32'hcafe_0001;
        step();
        step();
        rst = 0;
        idle_inputs();
        step();

        // CPU priority over a simultaneous background request
        cpu_wr = 1; cpu_addr = 14'h0010; cpu_wdata = 32'hdead_beef;
        dma_req = 1; dma_we = 0; dma_addr = 14'h0020;
        step();
        chk("prio_run_is_1", 32'(m_run), 32'd1);
        idle_inputs();
        step();

        // Idle grant and read return
        dma_req = 1; dma_we = 0; dma_addr = 14'h0020;
        step();
        chk("idle_gnt", 32'(m_last_gnt), 32'd1);
        dma_req = 0; ram_rdata = 32'h1234_5678;
        step();
        chk("idle_rdata", dma_rdata, 32'h1234_5678);
        ram_rdata = 32'h0;
        step();

        // Starvation: forced grant on every 9th cycle
        stalls = 0;
        cpu_rd = 1; cpu_addr = 14'h0100; dma_req = 1; dma_we = 1; dma_addr = 14'h0200;
        dma_wdata = 32'h5a5a_a5a5;
        for (int i = 0; i < 27; i++) begin
            step();
            chk("starve_pos", 32'(m_last_stall), 32'(i % 9 == 8));
            stalls += int'(m_last_stall);
        end
        chk("starve_count", 32'(stalls), 32'd3);

        // Request withdrawn after 5 denials
        dma_req = 0;
        step();
        stalls = 0;
        dma_req = 1;
        for (int i = 0; i < 5; i++) step();
        dma_req = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            stalls += int'(m_last_stall);
        end
        chk("withdraw_no_stall", 32'(stalls), 32'd0);

        // Request drops as the forced cycle begins
        dma_req = 1; dma_we = 0;
        for (int i = 0; i < c_LIMIT; i++) step();
        dma_req = 0;
        step();
        chk("drop_stall", 32'(m_last_stall), 32'd1);
        chk("drop_gnt", 32'(m_last_gnt), 32'd0);
        step();
        chk("drop_back_cpu", 32'(m_last_stall), 32'd0);

        // Reset on the edge after a background read grant
        idle_inputs();
        dma_req = 1; dma_we = 0; dma_addr = 14'h0030;
        step();
        rst = 1; dma_req = 0; ram_rdata = 32'hbad0_bad0;
        step();
        rst = 0;
        step();
        chk("rst_rvalid", 32'(dma_rvalid), 32'd0);

        // Random traffic with a legal handshake
        idle_inputs();
        for (int i = 0; i < 800; i++) begin
            bit busy_phase;
            busy_phase = ((i / 40) % 2) == 1;
            cpu_rd = 0; cpu_wr = 0;
            case ($urandom_range(0, 3))
                0: ;
                1: cpu_rd = 1;
                2: cpu_wr = 1;
                default: begin cpu_rd = 1; cpu_wr = 1; end
            endcase
            if (!busy_phase && $urandom_range(0, 1) == 0) begin cpu_rd = 0; cpu_wr = 0; end
            cpu_addr  = 14'($urandom);
            cpu_wdata = $urandom;
            ram_rdata = $urandom;
            if (!dma_req || m_last_gnt) begin
                dma_req   = ($urandom_range(0, 2) != 0);
                dma_we    = 1'($urandom);
                dma_addr  = 14'($urandom);
                dma_wdata = $urandom;
            end else if ($urandom_range(0, 15) == 0) begin
                dma_req = 0;
            end
            if ($urandom_range(0, 199) == 0) rst = 1;
            step();
            rst = 0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
